// File: rtl/fetch_controller.sv
// fetch_controller: program counter, instruction memory read sequencing and a
// small prefetch FIFO feeding decode over a valid/ready handshake. Branch or
// exception redirects flush the FIFO and reload the PC.
// Optional feature: define FETCH_PERF_EN to add the perf_fetched/perf_flushed
// event counters and their output ports.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   pc_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  // Prefetch storage: fetched word and the address it came from.
  logic [31:0] word_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic        push;
  logic        pop;
  logic        fifo_nonempty;
  logic [31:0] redirect_target;

  // Redirect targets are always word aligned; the low address bits are dropped.
  assign redirect_target = redirect_pc & ~32'h0000_0003;
  assign fifo_nonempty   = (count_reg != '0);

  // Handshake decode: a redirect suppresses both push and pop, and a full
  // FIFO may still push when its head leaves in the same cycle.
  always_comb begin
    pop  = fifo_nonempty & inst_ready & ~redirect_valid;
    push = fetch_en & ~redirect_valid & ((count_reg < CW'(DEPTH)) | pop);
  end

  // Outputs: the memory always sees the current PC; the head entry is shown
  // only when something is buffered, zero otherwise.
  always_comb begin
    imem_a     = pc_reg;
    inst_valid = fifo_nonempty & ~redirect_valid;
    inst       = '0;
    inst_pc    = '0;
    if (fifo_nonempty) begin
      inst    = word_mem[rd_ptr_reg];
      inst_pc = pc_mem[rd_ptr_reg];
    end
  end

  // PC, pointers and occupancy; reset wins over redirect, redirect over push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect_valid) begin
      pc_reg     <= redirect_target;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        pc_reg     <= pc_reg + 32'd4;
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry write: capture the word read at the current PC together with the PC.
  // Storage needs no reset because occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      word_mem[wr_ptr_reg] <= imem_rd;
      pc_mem[wr_ptr_reg]   <= pc_reg;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_flushed_reg;

  // Event counters: words fetched, and buffered words discarded by redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_reg <= '0;
      perf_flushed_reg <= '0;
    end else if (redirect_valid) begin
      perf_flushed_reg <= perf_flushed_reg + 32'(count_reg);
    end else if (push) begin
      perf_fetched_reg <= perf_fetched_reg + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_flushed = perf_flushed_reg;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the fetch
// buffer. Honours FETCH_PERF_EN when it is defined.
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x1000 + i, combinational read.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h0000_1000 + (addr >> 2);
  endfunction

  assign imem_rd = mem_word(imem_a);

  fetch_controller #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  // Reference model: a queue of {pc, word} entries plus the next fetch address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, compare outputs against
  // the model, then advance the model to what the next rising edge does.
  task automatic step(input logic rst, input logic fe, input logic rdy,
                      input logic rv, input logic [31:0] rpc);
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        do_pop;
    logic        do_push;
    entry_t      e;
    @(negedge clk);
    reset          = rst;
    fetch_en       = fe;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    exp_valid = (m_q.size() != 0) && !rv;
    exp_inst  = (m_q.size() != 0) ? m_q[0].word : 32'h0;
    exp_pc    = (m_q.size() != 0) ? m_q[0].pc   : 32'h0;
    check("imem_a",     imem_a,            m_pc);
    check("inst_valid", {31'h0, inst_valid}, {31'h0, exp_valid});
    check("inst",       inst,              exp_inst);
    check("inst_pc",    inst_pc,           exp_pc);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_flushed", perf_flushed, m_flushed);
`endif
    $display("cyc t=%0t rst=%0d fe=%0d rdy=%0d rv=%0d rpc=%08h | a=%08h v=%0d inst=%08h pc=%08h occ=%0d",
             $time, rst, fe, rdy, rv, rpc, imem_a, inst_valid, inst, inst_pc, m_q.size());
    if (rst) begin
      m_q.delete();
      m_pc      = RESET_PC;
      m_fetched = 0;
      m_flushed = 0;
    end else if (rv) begin
      m_flushed = m_flushed + 32'(m_q.size());
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      do_pop  = (m_q.size() != 0) && rdy;
      do_push = fe && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.pc   = m_pc;
        e.word = mem_word(m_pc);
        m_q.push_back(e);
        m_pc      = m_pc + 32'd4;
        m_fetched = m_fetched + 32'd1;
      end
    end
  endtask

  initial begin
    logic [31:0] rpc;
    reset          = 1'b1;
    fetch_en       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    m_q.delete();
    m_pc      = RESET_PC;
    m_fetched = 0;
    m_flushed = 0;

    // T1: reset for two cycles, then PC steps through consecutive words.
    step(1, 1, 1, 0, 0);
    check("t1_reset_valid", {31'h0, inst_valid}, 32'h0);
    check("t1_reset_addr",  imem_a, RESET_PC);
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);

    // T2: decode stalled after reset; FIFO fills to four and the PC stops.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    check("t2_imem_a",  imem_a,  32'h10);
    check("t2_inst",    inst,    32'h1000);
    check("t2_inst_pc", inst_pc, 32'h0);

    // T3: decode ready, one instruction per cycle with no gaps.
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);

    // T4: full FIFO flushed by a redirect to an unaligned target.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 32'h43);
    check("t4_valid_redirect", {31'h0, inst_valid}, 32'h0);
    step(0, 1, 1, 0, 0);
    check("t4_valid_after", {31'h0, inst_valid}, 32'h0);
    check("t4_imem_a", imem_a, 32'h40);
`ifdef FETCH_PERF_EN
    check("t4_perf_flushed", perf_flushed, 32'd4);
`endif
    step(0, 1, 1, 0, 0);
    check("t4_first_pc",   inst_pc, 32'h40);
    check("t4_first_inst", inst,    32'h1010);
    step(0, 1, 1, 0, 0);
    check("t4_second_pc",  inst_pc, 32'h44);

    // T5: full FIFO with ready keeps occupancy at four, then drain with fetch off.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("t5_drained", {31'h0, inst_valid}, 32'h0);

    // T6: reset while three entries are buffered.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t6_valid", {31'h0, inst_valid}, 32'h0);
    check("t6_addr",  imem_a, RESET_PC);

    // Back-to-back redirects: the last target wins.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 32'h100);
    step(0, 1, 1, 1, 32'h205);
    step(0, 1, 1, 0, 0);
    check("b2b_addr", imem_a, 32'h204);

    // Random traffic, including redirects near the top of the address space.
    for (int i = 0; i < 600; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                        : 32'($urandom_range(0, 1023));
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0),
           rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
